// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the core's load/store control outputs. It takes
//   one request at a time and performs a sized, little-endian access to an
//   internal word-organised RAM. After WAIT_CYCLES wait states it answers with
//   a one-cycle done pulse. Loads also return data, qualified by rvalid.
//
// Parameters
//   AW          byte-address bits used (RAM depth = 2^(AW-2) words, wraps)
//   WAIT_CYCLES wait states between accept and response (0..15)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   mem_load, do_store  request strobes (both high -> store)
//   funct3              size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, wdata         byte address, store data (low lanes for SB/SH)
//   busy                request in progress (WAIT or RESP)
//   rdata, rvalid       load result, valid only while rvalid=1 (else 0)
//   done, err           completion pulse; err flags misaligned/illegal funct3
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int AW          = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_load,
    input  logic        do_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        done,
    output logic        err
);

    localparam int DEPTH = 1 << (AW - 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          lat_store;
    logic [2:0]    lat_f3;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_wdata;

    logic [31:0]   mem [DEPTH];

    // Upper address bits are intentionally ignored so addresses wrap.
    logic unused_addr;
    assign unused_addr = ^addr[31:AW];

    // RESP is a single cycle and the FSM leaves it on the next edge, so a
    // request presented during RESP is taken on that edge (back-to-back
    // operation); only WAIT ignores incoming strobes.
    logic accept;
    assign accept = (mem_load | do_store) && (state != S_WAIT);
    assign busy   = (state != S_IDLE);

    // With WAIT_CYCLES=0 the access happens on the accept edge itself, so the
    // access path must see the live inputs rather than the latched copies.
    logic          cur_store;
    logic [2:0]    cur_f3;
    logic [AW-1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic          enter_resp;

    always_comb begin
        if (accept) begin
            cur_store = do_store;
            cur_f3    = funct3;
            cur_addr  = addr[AW-1:0];
            cur_wdata = wdata;
        end else begin
            cur_store = lat_store;
            cur_f3    = lat_f3;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
        end
    end

    assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                        ((state == S_WAIT) && (cnt == 4'd0));

    // Access decode: error detection, store lane enables and load extraction.
    logic          acc_err;
    logic [3:0]    be;
    logic [31:0]   wmerge;
    logic [31:0]   rword;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   ldata;
    logic [AW-3:0] word_idx;

    assign word_idx = cur_addr[AW-1:2];
    assign rword    = mem[word_idx];

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        acc_err = 1'b0;
        be      = 4'b0000;
        wmerge  = cur_wdata;
        ldata   = 32'd0;
        rbyte   = rword[7:0];
        rhalf   = cur_addr[1] ? rword[31:16] : rword[15:0];

        case (cur_addr[1:0])
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase

        if (cur_f3 == 3'b011 || cur_f3 == 3'b110 || cur_f3 == 3'b111)
            acc_err = 1'b1;
        else if (cur_f3[1:0] == 2'b01 && cur_addr[0])
            acc_err = 1'b1;
        else if (cur_f3[1:0] == 2'b10 && cur_addr[1:0] != 2'b00)
            acc_err = 1'b1;

        case (cur_f3[1:0])
            2'b00: begin
                be     = 4'b0001 << cur_addr[1:0];
                wmerge = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be     = cur_addr[1] ? 4'b1100 : 4'b0011;
                wmerge = {2{cur_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase

        case (cur_f3)
            3'b000:  ldata = {{24{rbyte[7]}}, rbyte};
            3'b100:  ldata = {24'd0, rbyte};
            3'b001:  ldata = {{16{rhalf[15]}}, rhalf};
            3'b101:  ldata = {16'd0, rhalf};
            3'b010:  ldata = rword;
            default: ldata = 32'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lat_store <= 1'b0;
            lat_f3    <= 3'd0;
            lat_addr  <= '0;
            lat_wdata <= 32'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= 32'd0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= 32'd0;

            case (state)
                S_WAIT: begin
                    if (cnt == 4'd0) state <= S_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                default: begin
                    if (accept) begin
                        lat_store <= do_store;
                        lat_f3    <= funct3;
                        lat_addr  <= addr[AW-1:0];
                        lat_wdata <= wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase

            if (enter_resp) begin
                done <= 1'b1;
                err  <= acc_err;
                if (!cur_store && !acc_err) begin
                    rvalid <= 1'b1;
                    rdata  <= ldata;
                end
            end
        end
    end

    // NOTE: the RAM has no reset; clearing it would cost a per-word reset
    // network and its contents must survive rst anyway.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && cur_store && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wmerge[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed self-checking bench. Three responders share clk/rst:
//   index 0 has WAIT_CYCLES=1, index 1 has 3, index 2 has 0.
//   Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ml [3];
    logic        st [3];
    logic [2:0]  f3 [3];
    logic [31:0] ad [3];
    logic [31:0] wd [3];
    logic        busy [3];
    logic        rv [3];
    logic        dn [3];
    logic        er [3];
    logic [31:0] rd [3];

    int checks = 0;
    int errors = 0;

    dmem_responder #(.AW(12), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst(rst), .mem_load(ml[0]), .do_store(st[0]), .funct3(f3[0]),
        .addr(ad[0]), .wdata(wd[0]), .busy(busy[0]), .rdata(rd[0]),
        .rvalid(rv[0]), .done(dn[0]), .err(er[0]));

    dmem_responder #(.AW(12), .WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .rst(rst), .mem_load(ml[1]), .do_store(st[1]), .funct3(f3[1]),
        .addr(ad[1]), .wdata(wd[1]), .busy(busy[1]), .rdata(rd[1]),
        .rvalid(rv[1]), .done(dn[1]), .err(er[1]));

    dmem_responder #(.AW(12), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .mem_load(ml[2]), .do_store(st[2]), .funct3(f3[2]),
        .addr(ad[2]), .wdata(wd[2]), .busy(busy[2]), .rdata(rd[2]),
        .rvalid(rv[2]), .done(dn[2]), .err(er[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic l, input logic s, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] w);
        ml[k] = l; st[k] = s; f3[k] = f; ad[k] = a; wd[k] = w;
    endtask

    task automatic clear(input int k);
        drive(k, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    endtask

    // Present one request for a single edge, then wait (bounded) for done.
    // lat counts edges from the accept edge; -1 means done never arrived.
    task automatic req(input int k, input logic l, input logic s, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] w,
                       output int lat, output logic [31:0] data, output logic v, output logic e);
        @(negedge clk);
        drive(k, l, s, f, a, w);
        @(posedge clk);
        #1;
        clear(k);
        lat = -1; data = 32'd0; v = 1'b0; e = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (dn[k]) begin
                lat = c; data = rd[k]; v = rv[k]; e = er[k];
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_chk(input int k, input string tag, input logic [2:0] f,
                            input logic [31:0] a, input logic [31:0] exp, input int exp_lat);
        int lat; logic [31:0] data; logic v, e;
        req(k, 1'b1, 1'b0, f, a, 32'd0, lat, data, v, e);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rvalid"}, {31'd0, v}, 32'd1);
        check({tag, " err"}, {31'd0, e}, 32'd0);
        check({tag, " rdata"}, data, exp);
    endtask

    task automatic store_chk(input int k, input string tag, input logic l, input logic [2:0] f,
                             input logic [31:0] a, input logic [31:0] w, input int exp_lat);
        int lat; logic [31:0] data; logic v, e;
        req(k, l, 1'b1, f, a, w, lat, data, v, e);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rvalid"}, {31'd0, v}, 32'd0);
        check({tag, " err"}, {31'd0, e}, 32'd0);
        check({tag, " rdata"}, data, 32'd0);
    endtask

    task automatic err_chk(input int k, input string tag, input logic l, input logic s,
                           input logic [2:0] f, input logic [31:0] a, input int exp_lat);
        int lat; logic [31:0] data; logic v, e;
        req(k, l, s, f, a, 32'hFFFF_FFFF, lat, data, v, e);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " err"}, {31'd0, e}, 32'd1);
        check({tag, " rvalid"}, {31'd0, v}, 32'd0);
        check({tag, " rdata"}, data, 32'd0);
    endtask

    // Count done pulses on responder k over n edges.
    task automatic count_done(input int k, input int n, output int nd);
        nd = 0;
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            if (dn[k]) nd++;
        end
    endtask

    initial begin
        int nd;
        logic [31:0] got;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) clear(k);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy[0]}, 32'd0);
        check("reset done", {31'd0, dn[0]}, 32'd0);
        check("reset rvalid", {31'd0, rv[0]}, 32'd0);
        check("reset err", {31'd0, er[0]}, 32'd0);
        check("reset rdata", rd[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // WAIT_CYCLES=1: basic word, sub-word and merge behaviour.
        store_chk(0, "SW 010", 1'b0, 3'b010, 32'h010, 32'hDEAD_BEEF, 2);
        load_chk(0, "LW 010", 3'b010, 32'h010, 32'hDEAD_BEEF, 2);
        load_chk(0, "LB 013", 3'b000, 32'h013, 32'hFFFF_FFDE, 2);
        load_chk(0, "LBU 013", 3'b100, 32'h013, 32'h0000_00DE, 2);
        load_chk(0, "LH 010", 3'b001, 32'h010, 32'hFFFF_BEEF, 2);
        load_chk(0, "LHU 012", 3'b101, 32'h012, 32'h0000_DEAD, 2);
        store_chk(0, "SB 011", 1'b0, 3'b000, 32'h011, 32'h0000_0055, 2);
        store_chk(0, "SH 012", 1'b0, 3'b001, 32'h012, 32'h0000_1234, 2);
        load_chk(0, "LW merged", 3'b010, 32'h010, 32'h1234_55EF, 2);
        // Address wraps above bit 11.
        load_chk(0, "LW wrap", 3'b010, 32'h0000_1010, 32'h1234_55EF, 2);

        // Errors: misaligned and illegal funct3; memory must stay intact.
        err_chk(0, "LW 012 misaligned", 1'b1, 1'b0, 3'b010, 32'h012, 2);
        err_chk(0, "SH 011 misaligned", 1'b0, 1'b1, 3'b001, 32'h011, 2);
        err_chk(0, "SW f3=110", 1'b0, 1'b1, 3'b110, 32'h010, 2);
        load_chk(0, "LW after errors", 3'b010, 32'h010, 32'h1234_55EF, 2);
        err_chk(0, "load f3=011", 1'b1, 1'b0, 3'b011, 32'h010, 2);

        // Both strobes high -> store.
        store_chk(0, "both strobes SW 020", 1'b1, 3'b010, 32'h020, 32'h0000_0011, 2);
        load_chk(0, "LW 020", 3'b010, 32'h020, 32'h0000_0011, 2);

        // WAIT_CYCLES=0: response on the cycle after the accept edge.
        store_chk(2, "W0 SW 040", 1'b0, 3'b010, 32'h040, 32'hCAFE_F00D, 1);
        load_chk(2, "W0 LW 040", 3'b010, 32'h040, 32'hCAFE_F00D, 1);
        load_chk(2, "W0 LBU 041", 3'b100, 32'h041, 32'h0000_00F0, 1);

        // WAIT_CYCLES=3.
        store_chk(1, "W3 SW 030", 1'b0, 3'b010, 32'h030, 32'h0102_0304, 4);

        // Requests pulsed while busy are ignored: a store attempt is held
        // through all three WAIT cycles and dropped before RESP.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 3'b010, 32'h030, 32'd0);
        @(posedge clk);
        #1;
        drive(1, 1'b0, 1'b1, 3'b010, 32'h030, 32'd0);
        check("busy in WAIT", {31'd0, busy[1]}, 32'd1);
        nd = 0;
        got = 32'd0;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk);
            #1;
            if (j == 3) clear(1);
            if (dn[1]) begin
                nd++;
                got = rd[1];
            end
        end
        check("busy ignore done count", 32'(nd), 32'd1);
        check("busy ignore rdata", got, 32'h0102_0304);
        load_chk(1, "W3 LW after ignored SW", 3'b010, 32'h030, 32'h0102_0304, 4);

        // Reset during WAIT discards the pending store.
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 3'b010, 32'h030, 32'hA5A5_A5A5);
        @(posedge clk);
        #1;
        clear(1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("busy after reset in WAIT", {31'd0, busy[1]}, 32'd0);
        count_done(1, 6, nd);
        check("no done after reset in WAIT", 32'(nd), 32'd0);
        load_chk(1, "W3 LW after reset in WAIT", 3'b010, 32'h030, 32'h0102_0304, 4);

        // Reset on the RESP-entry edge: no write, no done.
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 3'b010, 32'h030, 32'hA5A5_A5A5);
        @(posedge clk);
        #1;
        clear(1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("no done at reset on RESP entry", {31'd0, dn[1]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_done(1, 6, nd);
        check("no late done after RESP-entry reset", 32'(nd), 32'd0);
        load_chk(1, "W3 LW after RESP-entry reset", 3'b010, 32'h030, 32'h0102_0304, 4);

        // Other responders kept their RAM through the resets.
        load_chk(0, "W1 LW after resets", 3'b010, 32'h010, 32'h1234_55EF, 2);
        load_chk(2, "W0 LW after resets", 3'b010, 32'h040, 32'hCAFE_F00D, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
